// File: rtl/uart_tx_pkg.sv
// Shared UART TX encodings: FSM state codes and TX output mux selects.
package uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_STOP2  = 3'd5;

  // 3'b000 is deliberately left unused so a stuck-low select is visible on the line.
  localparam logic [2:0] MUX_SEL_START  = 3'b111;
  localparam logic [2:0] MUX_SEL_STOP   = 3'b001;
  localparam logic [2:0] MUX_SEL_DATA   = 3'b010;
  localparam logic [2:0] MUX_SEL_PARITY = 3'b011;

endpackage

// File: rtl/uart_tx_bitcnt.sv
// Data-bit counter for the UART TX sequencer: synchronous clear, increment, last-bit flag.
// Flags are combinational from the count; clear has priority over increment.
module uart_tx_bitcnt #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic incr,
  output logic last_bit,
  output logic past_end
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (incr) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign last_bit = (cnt == LAST);
  // Only reachable through a corrupted count; the FSM uses it to bail out to STOP.
  assign past_end = (cnt > LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: one bit per CLK, ack is combinational, start bit reaches TX_OUT 2 cycles after ack.
// Requests are held off (no ack) outside IDLE/final stop; optional second stop bit under UART_TX_CTRL_STOP2_EN.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       data_valid,
  input  logic       par_en,
`ifdef UART_TX_CTRL_STOP2_EN
  input  logic       stop2,
`endif
  output logic       data_ack,
  output logic       ser_shift,
  output logic [2:0] mux_sel,
  output logic       busy
);

  state_t state_q, state_d;
  logic   par_q;
  logic   final_stop;
  logic   last_bit, past_end;
  logic   cnt_clr, cnt_inc;

`ifdef UART_TX_CTRL_STOP2_EN
  logic stop2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stop2_q <= 1'b0;
    end else if (data_ack) begin
      stop2_q <= stop2;
    end
  end

  assign final_stop = ((state_q == ST_STOP) && !stop2_q) || (state_q == ST_STOP2);
`else
  assign final_stop = (state_q == ST_STOP);
`endif

  // Reset gating keeps ack low even while RST is held with a request pending.
  assign data_ack = data_valid && !RST && ((state_q == ST_IDLE) || final_stop);
  assign cnt_inc  = (state_q == ST_DATA);
  assign cnt_clr  = data_ack || (cnt_inc && (last_bit || past_end));

  uart_tx_bitcnt #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bitcnt (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (cnt_clr),
    .incr    (cnt_inc),
    .last_bit(last_bit),
    .past_end(past_end)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (data_valid) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA: begin
        if (past_end)      state_d = ST_STOP;
        else if (last_bit) state_d = par_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_d = ST_STOP;
`ifdef UART_TX_CTRL_STOP2_EN
      ST_STOP: begin
        if (stop2_q)         state_d = ST_STOP2;
        else if (data_valid) state_d = ST_START;
        else                 state_d = ST_IDLE;
      end
      ST_STOP2:  state_d = data_valid ? ST_START : ST_IDLE;
`else
      ST_STOP:   state_d = data_valid ? ST_START : ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (data_ack) par_q <= par_en;
    end
  end

  always_comb begin
    mux_sel   = MUX_SEL_STOP;
    busy      = 1'b1;
    ser_shift = 1'b0;
    case (state_q)
      ST_IDLE:   busy = 1'b0;
      ST_START:  mux_sel = MUX_SEL_START;
      ST_DATA: begin
        mux_sel   = MUX_SEL_DATA;
        ser_shift = 1'b1;
      end
      ST_PARITY: mux_sel = MUX_SEL_PARITY;
      ST_STOP:   mux_sel = MUX_SEL_STOP;
      ST_STOP2:  mux_sel = MUX_SEL_STOP;
      default:   busy = 1'b0;
    endcase
  end

endmodule
